// File: rtl/lane_clk_en_gen.sv
// lane_clk_en_gen: multi-channel phase-accumulator clock-enable generator with a
// downstream reset sequencer. Each channel adds its increment every enabled
// cycle; the registered carry is a one-cycle strobe at f_clk * inc / 2^ACC_W.
// rst_out_n/ready release after RST_HOLD strobes of channel RST_CH.
// Optional feature macro: STROBE_CNT_EN adds a 16-bit strobe counter per channel
// on output strobe_cnt.
module lane_clk_en_gen #(
    parameter int          NUM_CH   = 4,
    parameter int          ACC_W    = 16,
    parameter logic [31:0] INIT_INC = 32'h2000,
    parameter int          RST_CH   = 0,
    parameter int          RST_HOLD = 3
) (
    input  logic                    local_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    inc_wr,
    input  logic [$clog2(NUM_CH):0] inc_sel,
    input  logic [ACC_W-1:0]        inc_data,
    output logic                    inc_ack,
    output logic                    inc_err,
    output logic [NUM_CH-1:0]       strobe,
    output logic                    rst_out_n,
    output logic                    ready
`ifdef STROBE_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]    strobe_cnt
`endif
);

    localparam int SEL_W = $clog2(NUM_CH) + 1;
    localparam logic [SEL_W-1:0] NUM_CH_SEL = SEL_W'(NUM_CH);
    localparam logic [7:0]       HOLD_LAST  = 8'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_COUNT,
        ST_RUN
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       ack_reg, err_reg;
    logic       sel_bad;

    assign sel_bad = (inc_sel >= NUM_CH_SEL);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] inc_reg;
            logic             strobe_reg;
            logic [ACC_W:0]   sum;
            logic             run;
            logic             wr_hit;

            assign sum    = {1'b0, acc_reg} + {1'b0, inc_reg};
            assign run    = enable && ch_en[gi];
            assign wr_hit = inc_wr && (inc_sel == SEL_W'(gi));
            assign strobe[gi] = strobe_reg;

            // Accumulate when running; the add in the write cycle still uses the old increment.
            always_ff @(posedge local_clk) begin
                if (!rst) begin
                    acc_reg    <= '0;
                    inc_reg    <= INIT_INC[ACC_W-1:0];
                    strobe_reg <= 1'b0;
                end else begin
                    if (run) begin
                        acc_reg    <= sum[ACC_W-1:0];
                        strobe_reg <= sum[ACC_W];
                    end else begin
                        strobe_reg <= 1'b0;
                    end
                    if (wr_hit) begin
                        inc_reg <= inc_data;
                    end
                end
            end

`ifdef STROBE_CNT_EN
            logic [15:0] scnt_reg;

            // Count issued strobes; wraps naturally at 16 bits.
            always_ff @(posedge local_clk) begin
                if (!rst) begin
                    scnt_reg <= '0;
                end else if (run && sum[ACC_W]) begin
                    scnt_reg <= scnt_reg + 16'd1;
                end
            end

            assign strobe_cnt[gi*16 +: 16] = scnt_reg;
`endif
        end
    endgenerate

    // Write acknowledge and range error, one cycle after the request.
    always_ff @(posedge local_clk) begin
        if (!rst) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ack_reg <= inc_wr;
            err_reg <= inc_wr && sel_bad;
        end
    end

    assign inc_ack = ack_reg;
    assign inc_err = err_reg;

    // Reset sequencer state register.
    always_ff @(posedge local_clk) begin
        if (!rst) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Reset sequencer next state: count visible strobes of RST_CH only while it runs.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_HOLD: begin
                state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (strobe[RST_CH] && enable && ch_en[RST_CH]) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    assign rst_out_n = (state_reg == ST_RUN);
    assign ready     = (state_reg == ST_RUN);

endmodule
